pipeline_hazard_ctrl: RTL and testbench

Central stall/flush sequencer for the 5-stage MIPS pipeline. It sits beside the EX-stage forwarding logic and covers the hazards forwarding cannot resolve:
- load-use stalls
- control-hazard flushes
- multi-cycle MUL/DIV occupancy
- interrupt entry

It drives the PC and the IF/ID and ID/EX pipeline-register enables and flushes from one prioritised FSM.

---
 rtl/pipeline_pkg.sv | 10 +
 rtl/pipeline_hazard_ctrl_hazard_detect.sv | 14 +
 rtl/pipeline_hazard_ctrl.sv | 116 +++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 111 +++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// pipeline_pkg: shared FSM encoding and constants for the MIPS pipeline control blocks.
package pipeline_pkg;
    typedef enum logic [1:0] {
        RUN     = 2'b00,
        MDBUSY  = 2'b01,
        INTHOLD = 2'b10
    } state_t;
    localparam logic [31:0] EXC_VECTOR = 32'h8000_0180;
    localparam logic [4:0]  REG_ZERO   = 5'd0;
endpackage

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// hazard_detect: combinational load-use detection between the EX load and the ID sources.
module hazard_detect
    import pipeline_pkg::*;
(
    input  logic       MemReadEX,
    input  logic [4:0] regwriteaddrEX,
    input  logic [4:0] rsaddrID,
    input  logic [4:0] rtaddrID,
    input  logic       UseRtID,
    output logic       lu
);
    assign lu = MemReadEX && (regwriteaddrEX != REG_ZERO) &&
                ((regwriteaddrEX == rsaddrID) || (UseRtID && (regwriteaddrEX == rtaddrID)));
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: prioritised stall/flush sequencer for load-use, control,
// MUL/DIV occupancy and interrupt-entry hazards.
module pipeline_hazard_ctrl
    import pipeline_pkg::*;
#(
    parameter int MULDIV_CYCLES = 32,
    parameter int CNT_W         = 6
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       intterupt,
    input  logic       IntEnable,
    input  logic       MemReadEX,
    input  logic [4:0] regwriteaddrEX,
    input  logic [4:0] rsaddrID,
    input  logic [4:0] rtaddrID,
    input  logic       UseRtID,
    input  logic       JumpID,
    input  logic       BranchTakenEX,
    input  logic       MulDivStartEX,
    input  logic       MulDivReqID,
    output logic       PCWrite,
    output logic       IFIDWrite,
    output logic       IFIDFlush,
    output logic       IDEXBubble,
    output logic       PCSelInt,
    output logic       IntAck,
    output logic       MulDivBusy,
    output logic       MulDivDone
);
    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               lu, mdh, int_c;

    hazard_detect u_hazard_detect (
        .MemReadEX      (MemReadEX),
        .regwriteaddrEX (regwriteaddrEX),
        .rsaddrID       (rsaddrID),
        .rtaddrID       (rtaddrID),
        .UseRtID        (UseRtID),
        .lu             (lu)
    );

    assign mdh   = (state_q == MDBUSY) && MulDivReqID;
    assign int_c = intterupt && IntEnable && (state_q == RUN);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        PCWrite    = 1'b1;
        IFIDWrite  = 1'b1;
        IFIDFlush  = 1'b0;
        IDEXBubble = 1'b0;
        PCSelInt   = 1'b0;
        IntAck     = 1'b0;
        MulDivBusy = 1'b0;
        MulDivDone = 1'b0;
        if (int_c) begin
            IntAck     = 1'b1;
            PCSelInt   = 1'b1;
            IFIDFlush  = 1'b1;
            IDEXBubble = 1'b1;
        end else if (BranchTakenEX) begin
            IFIDFlush  = 1'b1;
            IDEXBubble = 1'b1;
        end else if (lu || mdh) begin
            PCWrite    = 1'b0;
            IFIDWrite  = 1'b0;
            IDEXBubble = 1'b1;
        end else if (JumpID) begin
            IFIDFlush  = 1'b1;
        end
        // An interrupt coincident with a MUL/DIV start squashes it; it re-executes after the handler.
        case (state_q)
            RUN: begin
                if (int_c) begin
                    state_d = INTHOLD;
                end else if (MulDivStartEX) begin
                    state_d = MDBUSY;
                    cnt_d   = CNT_W'(MULDIV_CYCLES - 1);
                end
            end
            MDBUSY: begin
                MulDivBusy = 1'b1;
                if (cnt_q == '0) begin
                    MulDivDone = 1'b1;
                    state_d    = RUN;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            INTHOLD: state_d = intterupt ? INTHOLD : RUN;
            default: state_d = RUN;
        endcase
        if (reset) begin
            PCWrite    = 1'b0;
            IFIDWrite  = 1'b0;
            IFIDFlush  = 1'b1;
            IDEXBubble = 1'b1;
            PCSelInt   = 1'b0;
            IntAck     = 1'b0;
            MulDivBusy = 1'b0;
            MulDivDone = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed and randomized checks against a cycle-count reference model.
module tb_pipeline_hazard_ctrl;
    localparam int N = 4;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic intterupt = 1'b0, IntEnable = 1'b0, MemReadEX = 1'b0, UseRtID = 1'b0;
    logic JumpID = 1'b0, BranchTakenEX = 1'b0, MulDivStartEX = 1'b0, MulDivReqID = 1'b0;
    logic [4:0] regwriteaddrEX = '0, rsaddrID = '0, rtaddrID = '0;
    logic PCWrite, IFIDWrite, IFIDFlush, IDEXBubble, PCSelInt, IntAck, MulDivBusy, MulDivDone;
    int checks = 0, errors = 0;
    int m_busy = 0;
    bit m_hold = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.MULDIV_CYCLES(N), .CNT_W(3)) dut (
        .clk(clk), .reset(reset), .intterupt(intterupt), .IntEnable(IntEnable),
        .MemReadEX(MemReadEX), .regwriteaddrEX(regwriteaddrEX), .rsaddrID(rsaddrID),
        .rtaddrID(rtaddrID), .UseRtID(UseRtID), .JumpID(JumpID), .BranchTakenEX(BranchTakenEX),
        .MulDivStartEX(MulDivStartEX), .MulDivReqID(MulDivReqID), .PCWrite(PCWrite),
        .IFIDWrite(IFIDWrite), .IFIDFlush(IFIDFlush), .IDEXBubble(IDEXBubble),
        .PCSelInt(PCSelInt), .IntAck(IntAck), .MulDivBusy(MulDivBusy), .MulDivDone(MulDivDone)
    );

    function automatic logic [7:0] outs();
        return {PCWrite, IFIDWrite, IFIDFlush, IDEXBubble, PCSelInt, IntAck, MulDivBusy, MulDivDone};
    endfunction

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, got, exp);
        end
    endtask

    // Drives one cycle at the negedge, checks the combinational outputs, then advances the model.
    task automatic cyc(input string tag, input logic irq, en, mr, input logic [4:0] wa, rs, rt,
                       input logic urt, j, br, st, req);
        bit busy, intc, lu, stall;
        intterupt = irq; IntEnable = en; MemReadEX = mr; regwriteaddrEX = wa;
        rsaddrID = rs; rtaddrID = rt; UseRtID = urt; JumpID = j; BranchTakenEX = br;
        MulDivStartEX = st; MulDivReqID = req;
        #1;
        busy  = m_busy > 0;
        intc  = irq && en && !busy && !m_hold;
        lu    = mr && wa != 0 && (wa == rs || (urt && wa == rt));
        stall = !intc && !br && (lu || (busy && req));
        chk(tag, outs(), {!stall, !stall, intc || br || (j && !stall), intc || br || stall,
                          intc, intc, busy, busy && m_busy == 1});
        chk("no_start_while_busy", {7'b0, MulDivStartEX && MulDivBusy}, 8'd0);
        if (busy) m_busy--;
        else if (m_hold) m_hold = irq;
        else if (intc) m_hold = 1;
        else if (st) m_busy = N;
        @(negedge clk);
    endtask

    initial begin
        bit irq = 0;
        #1;
        chk("reset_outputs", outs(), 8'b0011_0000);
        @(negedge clk);
        reset = 1'b0;
        cyc("idle",          0,1, 0,5'd0,5'd0,5'd0, 0,0,0,0,0);
        cyc("lu_stall",      0,1, 1,5'd5,5'd5,5'd1, 0,0,0,0,0);
        cyc("lu_released",   0,1, 0,5'd0,5'd5,5'd1, 0,0,0,0,0);
        cyc("lu_rt",         0,1, 1,5'd7,5'd1,5'd7, 1,0,0,0,0);
        cyc("lu_rt_unused",  0,1, 1,5'd7,5'd1,5'd7, 0,0,0,0,0);
        cyc("lu_reg0",       0,1, 1,5'd0,5'd0,5'd0, 1,0,0,0,0);
        cyc("branch_lu",     0,1, 1,5'd5,5'd5,5'd1, 0,0,1,0,0);
        cyc("jump",          0,1, 0,5'd0,5'd0,5'd0, 0,1,0,0,0);
        cyc("jump_lu",       0,1, 1,5'd3,5'd3,5'd0, 0,1,0,0,0);
        cyc("md_start",      0,1, 0,5'd0,5'd0,5'd0, 0,0,0,1,0);
        for (int i = 0; i < N; i++) cyc("md_mflo_stall", 0,1, 0,5'd0,5'd0,5'd0, 0,0,0,0,1);
        cyc("md_mflo_issue", 0,1, 0,5'd0,5'd0,5'd0, 0,0,0,0,1);
        cyc("md_start2",     0,1, 0,5'd0,5'd0,5'd0, 0,0,0,1,0);
        cyc("md_indep",      0,1, 0,5'd0,5'd2,5'd3, 1,0,0,0,0);
        for (int i = 1; i < N; i++) cyc("md_irq_defer", 1,1, 0,5'd0,5'd0,5'd0, 0,0,0,0,0);
        cyc("irq_ack",       1,1, 0,5'd0,5'd0,5'd0, 0,0,0,0,0);
        cyc("irq_held",      1,1, 0,5'd0,5'd0,5'd0, 0,0,0,0,0);
        cyc("irq_held2",     1,1, 0,5'd0,5'd0,5'd0, 0,0,0,0,0);
        cyc("irq_drop",      0,1, 0,5'd0,5'd0,5'd0, 0,0,0,0,0);
        cyc("irq_reraise",   1,1, 0,5'd0,5'd0,5'd0, 0,0,0,0,0);
        cyc("irq_drop2",     0,1, 0,5'd0,5'd0,5'd0, 0,0,0,0,0);
        for (int i = 0; i < 3; i++) cyc("irq_masked", 1,0, 0,5'd0,5'd0,5'd0, 0,0,0,0,0);
        cyc("irq_with_start",1,1, 0,5'd0,5'd0,5'd0, 0,0,0,1,0);
        cyc("inthold_no_md", 1,1, 0,5'd0,5'd0,5'd0, 0,0,0,0,1);
        cyc("inthold_exit",  0,1, 0,5'd0,5'd0,5'd0, 0,0,0,0,0);
        cyc("md_start3",     0,1, 0,5'd0,5'd0,5'd0, 0,0,0,1,0);
        cyc("md_busy_c3",    0,1, 0,5'd0,5'd0,5'd0, 0,0,0,0,0);
        reset = 1'b1;
        #1;
        chk("async_reset_mid_md", outs(), 8'b0011_0000);
        @(negedge clk);
        reset = 1'b0;
        m_busy = 0;
        m_hold = 0;
        cyc("after_reset",   0,1, 0,5'd0,5'd0,5'd0, 0,0,0,0,0);
        cyc("after_reset2",  0,1, 0,5'd0,5'd0,5'd0, 0,0,0,0,0);
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 9) == 0) irq = !irq;
            cyc("random", irq, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)), $urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0,
                m_busy == 0 && $urandom_range(0, 5) == 0, 1'($urandom_range(0, 1)));
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
